// File: rtl/ili9341_frame_source.sv
// Pixel-stream generator for ili9341_controller: palette x fill-mode frames over valid/ready.
// Build option: define FRAME_BORDER_EN to force an all-ones one-pixel border on every frame.
module ili9341_frame_source #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int PIXEL_SIZE = 16,
  parameter int IMAGENES   = 5,
  parameter int CELL_LOG2  = 4,
  localparam int SEL_W     = (IMAGENES > 1) ? $clog2(IMAGENES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [SEL_W-1:0]      visua,
  input  logic [1:0]            mode,
  output logic [PIXEL_SIZE-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_sof,
  output logic                  pix_eol,
  output logic                  pix_eof,
  output logic                  frame_done,
  output logic [SEL_W-1:0]      cur_image
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [SEL_W-1:0] r_img;
  logic [1:0]      r_mode;
  logic            r_valid;
  logic            r_done;

  logic            w_accept;
  logic            w_xlast;
  logic            w_ylast;
  logic            w_xbit;
  logic            w_ybit;
  logic            w_border;
  logic [PIXEL_SIZE-1:0] w_col;
  logic [PIXEL_SIZE-1:0] w_pix;

  function automatic logic [15:0] palette(input logic [SEL_W-1:0] idx);
    logic [15:0] c;
    case (32'(idx))
      32'd0:   c = 16'hFFE0;
      32'd1:   c = 16'h07FF;
      32'd2:   c = 16'hF800;
      32'd3:   c = 16'h780F;
      32'd4:   c = 16'h0000;
      default: c = 16'h001F;
    endcase
    return c;
  endfunction

  assign w_accept = r_valid & pix_ready;
  assign w_xlast  = (r_x == X_LAST);
  assign w_ylast  = (r_y == Y_LAST);

  // Cell bit may lie above the counter width; it then reads as zero.
  assign w_xbit = |((32'(r_x) >> CELL_LOG2) & 32'd1);
  assign w_ybit = |((32'(r_y) >> CELL_LOG2) & 32'd1);

  assign w_col = PIXEL_SIZE'(palette(r_img));

  always_comb begin
    w_pix = w_col;
    unique case (r_mode)
      2'd0: w_pix = w_col;
      2'd1: w_pix = w_xbit ? ~w_col : w_col;
      2'd2: w_pix = (w_xbit ^ w_ybit) ? ~w_col : w_col;
      2'd3: w_pix = ~w_col;
    endcase
  end

`ifdef FRAME_BORDER_EN
  assign w_border = (r_x == '0) | w_xlast | (r_y == '0) | w_ylast;
`else
  assign w_border = 1'b0;
`endif

  assign pix_data   = !r_valid ? '0 : (w_border ? '1 : w_pix);
  assign pix_valid  = r_valid;
  assign pix_sof    = r_valid & (r_x == '0) & (r_y == '0);
  assign pix_eol    = r_valid & w_xlast;
  assign pix_eof    = r_valid & w_xlast & w_ylast;
  assign frame_done = r_done;
  assign cur_image  = r_img;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_img   <= '0;
      r_mode  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          r_done  <= 1'b0;
          if (enable) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_img   <= (32'(visua) >= 32'(IMAGENES)) ? '0 : visua;
          r_mode  <= mode;
          r_x     <= '0;
          r_y     <= '0;
          r_valid <= 1'b1;
          r_done  <= 1'b0;
          r_state <= S_STREAM;
        end
        S_STREAM: begin
          if (w_accept) begin
            if (w_xlast && w_ylast) begin
              r_x     <= '0;
              r_y     <= '0;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if (w_xlast) begin
              r_x <= '0;
              r_y <= r_y + YW'(1);
            end else begin
              r_x <= r_x + XW'(1);
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_valid <= 1'b0;
          r_state <= enable ? S_LOAD : S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ili9341_frame_source.sv
// Directed bench for ili9341_frame_source on a 4x2 frame with a beat scoreboard.
module tb_ili9341_frame_source;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int CL = 1;
  localparam int PS = 16;
  localparam int IM = 5;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [SW-1:0] visua;
  logic [1:0]    mode;
  logic [PS-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_sof;
  logic          pix_eol;
  logic          pix_eof;
  logic          frame_done;
  logic [SW-1:0] cur_image;

  ili9341_frame_source #(
    .H_RES(H), .V_RES(V), .PIXEL_SIZE(PS), .IMAGENES(IM), .CELL_LOG2(CL)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .visua(visua), .mode(mode),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .frame_done(frame_done), .cur_image(cur_image)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        sof;
    logic        eol;
    logic        eof;
  } beat_t;

  beat_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input int vis, input int md, input int x, input int y);
    logic [15:0] pal [0:4];
    logic [15:0] c;
    logic xb;
    logic yb;
    pal[0] = 16'hFFE0;
    pal[1] = 16'h07FF;
    pal[2] = 16'hF800;
    pal[3] = 16'h780F;
    pal[4] = 16'h0000;
    c  = (vis >= IM) ? pal[0] : pal[vis];
    xb = ((x >> CL) & 1) != 0;
    yb = ((y >> CL) & 1) != 0;
    case (md)
      0: model = c;
      1: model = xb ? ~c : c;
      2: model = (xb ^ yb) ? ~c : c;
      default: model = ~c;
    endcase
`ifdef FRAME_BORDER_EN
    if (x == 0 || x == H - 1 || y == 0 || y == V - 1) model = 16'hFFFF;
`endif
  endfunction

  task automatic push_frame(input int vis, input int md);
    beat_t b;
    for (int i = 0; i < H * V; i++) begin
      b.d   = model(vis, md, i % H, i / H);
      b.sof = (i == 0);
      b.eol = ((i % H) == H - 1);
      b.eof = (i == H * V - 1);
      q.push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_beats(input int n, input bit stall);
    int got;
    int cyc;
    bit held;
    beat_t cur;
    beat_t prev;
    beat_t e;
    got = 0;
    cyc = 0;
    held = 0;
    prev = '0;
    while (got < n && cyc < 200) begin
      pix_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      cur = {pix_data, pix_sof, pix_eol, pix_eof};
      if (held) begin
        chk("stall_valid", 32'(pix_valid), 32'd1);
        chk("stall_hold", 32'(cur), 32'(prev));
      end
      held = 0;
      if (pix_valid) begin
        chk("busy_done", 32'(frame_done), 32'd0);
        if (pix_ready) begin
          if (q.size() == 0) begin
            chk("queue_underflow", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("beat", 32'(cur), 32'(e));
          end
          got++;
        end else begin
          held = 1;
          prev = cur;
        end
      end
      tick();
      cyc++;
    end
    pix_ready = 1'b1;
    if (got < n) chk("beat_timeout", 32'(got), 32'(n));
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    visua = '0;
    mode = '0;
    pix_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_data", 32'(pix_data), 32'd0);
    chk("rst_image", 32'(cur_image), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_valid", 32'(pix_valid), 32'd0);
      chk("idle_done", 32'(frame_done), 32'd0);
      chk("idle_data", 32'(pix_data), 32'd0);
    end

    // solid F800, latency and frame gap
    visua = 3'd2;
    mode = 2'd0;
    pix_ready = 1'b1;
    enable = 1'b1;
    push_frame(2, 0);
    tick();
    chk("lat1_valid", 32'(pix_valid), 32'd0);
    tick();
    chk("lat2_valid", 32'(pix_valid), 32'd1);
    run_beats(8, 0);
    chk("done_pulse", 32'(frame_done), 32'd1);
    chk("done_valid", 32'(pix_valid), 32'd0);

    // checker, visua=1
    visua = 3'd1;
    mode = 2'd2;
    push_frame(1, 2);
    tick();
    chk("gap_done", 32'(frame_done), 32'd0);
    chk("gap_valid", 32'(pix_valid), 32'd0);
    tick();
    chk("gap_end_valid", 32'(pix_valid), 32'd1);
    run_beats(8, 0);
    chk("done_checker", 32'(frame_done), 32'd1);

    // bars with random backpressure
    mode = 2'd1;
    push_frame(1, 1);
    tick();
    tick();
    run_beats(8, 1);
    chk("done_stall", 32'(frame_done), 32'd1);

    // visua change mid-frame
    mode = 2'd0;
    push_frame(1, 0);
    tick();
    tick();
    chk("img_start", 32'(cur_image), 32'd1);
    run_beats(3, 0);
    visua = 3'd3;
    chk("img_mid", 32'(cur_image), 32'd1);
    run_beats(5, 0);
    chk("img_done", 32'(cur_image), 32'd1);
    chk("done_mid", 32'(frame_done), 32'd1);
    push_frame(3, 0);
    tick();
    chk("img_load", 32'(cur_image), 32'd1);
    tick();
    chk("img_new", 32'(cur_image), 32'd3);
    visua = 3'd7;
    run_beats(8, 0);
    push_frame(7, 0);
    tick();
    tick();
    chk("img_oor", 32'(cur_image), 32'd0);
    run_beats(8, 0);
    chk("done_oor", 32'(frame_done), 32'd1);

    // reset mid-frame at beat 5
    visua = 3'd2;
    mode = 2'd3;
    push_frame(2, 3);
    tick();
    tick();
    run_beats(5, 0);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(pix_valid), 32'd0);
    chk("arst_data", 32'(pix_data), 32'd0);
    chk("arst_flags", 32'({pix_sof, pix_eol, pix_eof}), 32'd0);
    chk("arst_done", 32'(frame_done), 32'd0);
    q.delete();
    tick();
    rst = 1'b0;
    push_frame(2, 3);
    tick();
    chk("rst_nodone", 32'(frame_done), 32'd0);
    chk("rst_load_valid", 32'(pix_valid), 32'd0);
    tick();
    chk("restart_valid", 32'(pix_valid), 32'd1);
    run_beats(8, 0);
    chk("done_restart", 32'(frame_done), 32'd1);

    enable = 1'b0;
    tick();
    tick();
    chk("stop_valid", 32'(pix_valid), 32'd0);
    chk("stop_done", 32'(frame_done), 32'd0);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
